// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// spi_arbiter : round-robin arbiter sharing one SPI master among NUM_REQ users
// Optional watchdog on the master handshake: define SPI_ARB_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module spi_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 m_start,
    output logic [7:0]           m_tx_data,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic [7:0]           m_rx_data,
    output logic                 timeout_err
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     rr_idx;
    logic               found;
    logic               grant_fire;
    logic               timeout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    // Scan from ptr upward, wrapping, and keep the first requester found.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (rr_idx >= (PTR_W+1)'(NUM_REQ)) begin
                rr_idx = rr_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req[rr_idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = rr_idx[PTR_W-1:0];
            end
        end
    end

    assign grant_fire = (state == IDLE) && found && !m_busy && !rst;

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        m_start   = 1'b0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    gnt[winner] = 1'b1;
                    state_nx    = START;
                end
            end
            START: begin
                m_start  = 1'b1;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_done || timeout_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            m_tx_data <= 8'h00;
            rsp_data  <= 8'h00;
        end else begin
            state <= state_nx;
            if (grant_fire) begin
                owner     <= winner;
                m_tx_data <= req_data[{winner, 3'b000} +: 8];
                ptr       <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            end
            // m_done wins over a watchdog expiry in the same cycle.
            if (state == WAIT_DONE) begin
                if (m_done) begin
                    rsp_data <= m_rx_data;
                end else if (timeout_hit) begin
                    rsp_data <= 8'hFF;
                end
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    // wd_cnt holds the number of WAIT_DONE cycles already elapsed.
    assign timeout_hit = (state == WAIT_DONE) && !m_done &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state == WAIT_DONE && !m_done && !timeout_hit) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_arbiter : randomized scoreboard bench for spi_arbiter
// Revision: 1.0
// ============================================================================
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [7:0]     m_rx_data = 8'h00;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           m_start;
    logic [7:0]     m_tx_data;
    logic           timeout_err;

    spi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .m_start(m_start), .m_tx_data(m_tx_data), .m_busy(m_busy),
        .m_done(m_done), .m_rx_data(m_rx_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [7:0] data;
        bit         to;
    } rsp_t;

    int   checks = 0;
    int   failures = 0;
    rsp_t rsp_q[$];
    int   grant_log[$];
    bit   granted_seen[N];
    int   cur_owner = 0;
    bit   open = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Monitor / reference model: samples on the falling edge.
    int         cyc = 0;
    int         mptr = 0;
    bit         exp_start = 0;
    bit         exp_rsp = 0;
    logic [7:0] exp_tx = 8'h00;
    int         started_at = -1;
    bit         rst_q = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_g;
        int           w;
        rsp_t         r;
        cyc++;
        if (rst) begin
            if (rst_q) begin
                check("rst_gnt", 32'(gnt), 0);
                check("rst_rsp_valid", 32'(rsp_valid), 0);
                check("rst_m_start", 32'(m_start), 0);
                check("rst_m_tx_data", 32'(m_tx_data), 0);
                check("rst_rsp_data", 32'(rsp_data), 0);
                check("rst_timeout_err", 32'(timeout_err), 0);
            end
            mptr = 0; open = 0; exp_start = 0; exp_rsp = 0; started_at = -1;
            rsp_q.delete();
            for (int k = 0; k < N; k++) granted_seen[k] = 0;
        end else begin
            if (exp_start || m_start) begin
                check("m_start", 32'(m_start), 32'(exp_start));
                if (exp_start) begin
                    check("m_tx_data", 32'(m_tx_data), 32'(exp_tx));
                    started_at = cyc;
                end
                exp_start = 0;
            end
            exp_g = '0;
            w = -1;
            if (!open && !m_busy) w = rr_pick(req, mptr);
            if (w >= 0) exp_g[w] = 1'b1;
            if (gnt != 0 || exp_g != 0) check("gnt", 32'(gnt), 32'(exp_g));
            if (w >= 0) begin
                open = 1; cur_owner = w; exp_start = 1;
                exp_tx = req_data[8*w +: 8];
                mptr = (w + 1) % N;
                granted_seen[w] = 1;
                grant_log.push_back(w);
            end
`ifdef SPI_ARB_TIMEOUT_EN
            if (open && started_at >= 0 && !exp_rsp && cyc == started_at + TO + 1) exp_rsp = 1;
`endif
            if (exp_rsp || rsp_valid != 0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1) << r.owner);
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                    check("rsp_timeout_err", 32'(timeout_err), 32'(r.to));
                end
                exp_rsp = 0; open = 0; started_at = -1;
            end else if (timeout_err) begin
                check("timeout_err_stray", 32'(timeout_err), 0);
            end
            if (m_done && open && started_at >= 0 && cyc > started_at) exp_rsp = 1;
        end
        rst_q = rst;
    end

    // Stimulus: requesters and SPI master model, driven after the rising edge.
    initial begin
        int         mdelay = 0;
        bit         mactive = 0;
        bit         hang_next = 0;
        bit         hang_to = 0;
        int         rst_cnt = 0;
        int         busy_hold = 0;
        bit         did_rst = 0;
        bit         mode_all;
        bit         quiet;
        logic [7:0] mrx = 8'h00;
        int         exp_order[5] = '{0, 1, 2, 3, 0};

        for (int c = 0; c < 700; c++) begin
            @(posedge clk);
            #2;
            mode_all = (c >= 2 && c < 60);
            quiet    = (c >= 650);
            m_done   = 1'b0;
            if (c == 2) rst = 1'b0;
            if (c == 60) begin
                if (grant_log.size() < 5) begin
                    check("rr_order_len", 32'(grant_log.size()), 5);
                end else begin
                    for (int i = 0; i < 5; i++) check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
                end
            end
            if (c == 200) hang_next = 1;
            if (c >= 300 && !did_rst && mactive && !hang_to && mdelay > 1) begin
                did_rst = 1; rst = 1'b1; rst_cnt = 2; mactive = 0; m_busy = 1'b1;
            end else if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) begin
                    rst = 1'b0; busy_hold = 3;
                end
            end else if (c < 2) begin
                m_busy = 1'b0;
            end else if (busy_hold > 0) begin
                busy_hold--;
                m_busy = (busy_hold != 0);
            end else if (m_start && !mactive) begin
                mactive = 1; m_busy = 1'b1; hang_to = 0;
                mrx = 8'($urandom);
                mdelay = $urandom_range(1, 6);
                if (hang_next) begin
                    hang_next = 0;
`ifdef SPI_ARB_TIMEOUT_EN
                    hang_to = 1; mdelay = TO + 4;
                    rsp_q.push_back('{cur_owner, 8'hFF, 1'b1});
`else
                    mdelay = 20;
`endif
                end
            end else if (mactive) begin
                mdelay--;
                if (mdelay == 0) begin
                    mactive = 0; m_busy = 1'b0;
                    if (!hang_to) begin
                        m_done = 1'b1; m_rx_data = mrx;
                        rsp_q.push_back('{cur_owner, mrx, 1'b0});
                    end
                    hang_to = 0;
                end
            end else begin
                m_busy = ($urandom_range(0, 9) == 0);
                if (!m_busy && $urandom_range(0, 11) == 0) begin
                    m_done = 1'b1; m_rx_data = 8'($urandom);
                end
            end

            for (int k = 0; k < N; k++) begin
                if (granted_seen[k]) begin
                    granted_seen[k] = 0;
                    req[k] = mode_all;
                    if (mode_all) req_data[8*k +: 8] = 8'($urandom);
                end else if (quiet) begin
                    req[k] = 1'b0;
                end else if (!req[k]) begin
                    if (mode_all || $urandom_range(0, 3) == 0) begin
                        req[k] = 1'b1; req_data[8*k +: 8] = 8'($urandom);
                    end
                end else if (!mode_all && $urandom_range(0, 19) == 0) begin
                    req[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("drain_rsp_queue", 32'(rsp_q.size()), 0);
        check("drain_no_open_transfer", 32'(open), 0);
        check("saw_grants", 32'(grant_log.size() > 40), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one SPI master (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, is the watchdog limit in clk cycles (used only with REQ-030).
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester transfer request, level, held until gnt.
REQ-006 req_data  input  8*NUM_REQ  per-requester TX byte; slice k = bits [8k+7:8k].
REQ-007 gnt  output  NUM_REQ  one-hot, one-cycle grant pulse; req_data of the granted requester is captured in this cycle.
REQ-008 rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
REQ-009 rsp_data  output  8  received byte, valid only when any rsp_valid bit is high.
REQ-010 m_start  output  1  start pulse to SPI master.
REQ-011 m_tx_data  output  8  TX byte to SPI master, held stable from START until the response.
REQ-012 m_busy  input  1  SPI master busy.
REQ-013 m_done  input  1  SPI master one-cycle done pulse.
REQ-014 m_rx_data  input  8  SPI master received byte, valid with m_done.
REQ-015 timeout_err  output  1  one-cycle watchdog error pulse.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT_DONE and RESP.
REQ-017 IDLE: when any req bit is high and m_busy=0, the block SHALL select a winner, pulse gnt[winner], latch winner index and data, and go to START; otherwise it stays in IDLE.
REQ-018 Winner selection SHALL be round-robin: the first set req bit at or above pointer ptr, ascending, wrapping modulo NUM_REQ.
REQ-019 After a grant to index k, ptr SHALL become (k+1) mod NUM_REQ; with k = NUM_REQ-1, ptr wraps to 0.
REQ-020 START SHALL drive m_start=1 for exactly one cycle with m_tx_data = latched byte, then go to WAIT_DONE.
REQ-021 WAIT_DONE: on m_done=1, the block SHALL register m_rx_data and go to RESP.
REQ-022 RESP SHALL pulse rsp_valid[owner] for one cycle with rsp_data = the registered byte, then return to IDLE.
REQ-023 Latency from gnt to m_start SHALL be 1 cycle; from m_done to rsp_valid, 1 cycle; the earliest next gnt SHALL follow 1 cycle after rsp_valid.
REQ-024 m_done outside WAIT_DONE SHALL be ignored.
REQ-025 A req bit that drops before its gnt SHALL withdraw the request with no side effects; req changes after gnt SHALL not affect the transfer in flight.
REQ-026 At most one transfer SHALL be outstanding; gnt SHALL never assert outside IDLE.
REQ-027 m_tx_data SHALL hold its value outside START and WAIT_DONE; m_start, gnt, rsp_valid and timeout_err SHALL be 0 except in their defined cycles.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL enter IDLE with ptr=0, gnt=0, rsp_valid=0, rsp_data=8'h00, m_start=0, m_tx_data=8'h00, timeout_err=0 and the watchdog counter at 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no rsp_valid, and the next grant SHALL wait for m_busy=0.

Configuration
REQ-030 With SPI_ARB_TIMEOUT_EN defined: in WAIT_DONE, a counter SHALL count cycles from entry; if it reaches TIMEOUT_CYC with no m_done, the block SHALL pulse timeout_err, go to RESP with rsp_data=8'hFF, and clear the counter. m_done in the same cycle as the limit SHALL take priority over the timeout.
REQ-031 Without SPI_ARB_TIMEOUT_EN: no counter SHALL be built, timeout_err SHALL be tied to 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-032 Single requester: req=4'b0001, req_data[7:0]=8'hA5; master returns 8'h3C -> gnt[0], m_start with m_tx_data=8'hA5 one cycle later, rsp_valid[0] with rsp_data=8'h3C one cycle after m_done.
REQ-033 All four requesting continuously from reset -> grant order 0,1,2,3,0 and exactly one transfer in flight at any time.
REQ-034 ptr=3 with req=4'b1001 -> gnt[3] first, then gnt[0] (wrap-around).
REQ-035 req asserted while m_busy=1 in IDLE -> no gnt until m_busy=0; a spurious m_done in IDLE -> no rsp_valid.
REQ-036 rst=1 during WAIT_DONE -> all outputs at reset values, no rsp_valid; the next request is served normally.
REQ-037 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, no m_done -> timeout_err and rsp_valid[owner] with rsp_data=8'hFF after 8 cycles in WAIT_DONE; without the macro -> stays in WAIT_DONE.
